// File: rtl/wb_decoder_n.sv
// Wishbone single-master, N-slave address decoder with registered slave select and bus-error response.
// Define WB_DECODER_TIMEOUT_EN to turn a hung slave into a bus error after TIMEOUT cycles.
module wb_decoder_n #(
    parameter int                      NSLAVES    = 4,
    parameter int                      AW         = 32,
    parameter int                      DW         = 32,
    parameter logic [NSLAVES*AW-1:0]   SLAVE_BASE = {32'h8000_0000, 32'h4000_0000, 32'h0001_0000, 32'h0000_0000},
    parameter logic [NSLAVES*AW-1:0]   SLAVE_MASK = {32'hFF00_0000, 32'hC000_0000, 32'hFFFF_0000, 32'hFFFF_0000},
    parameter int                      TIMEOUT    = 255
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wb_cyc,
    input  logic                  i_wb_stb,
    input  logic                  i_wb_we,
    input  logic [AW-1:0]         i_wb_addr,
    input  logic [DW-1:0]         i_wb_data,
    input  logic [DW/8-1:0]       i_wb_sel,
    output logic                  o_wb_stall,
    output logic                  o_wb_ack,
    output logic                  o_wb_err,
    output logic [DW-1:0]         o_wb_data,
    output logic [NSLAVES-1:0]    o_s_cyc,
    output logic [NSLAVES-1:0]    o_s_stb,
    output logic                  o_s_we,
    output logic [AW-1:0]         o_s_addr,
    output logic [DW-1:0]         o_s_data,
    output logic [DW/8-1:0]       o_s_sel,
    input  logic [NSLAVES-1:0]    i_s_stall,
    input  logic [NSLAVES-1:0]    i_s_ack,
    input  logic [NSLAVES*DW-1:0] i_s_data,
    output logic                  o_busy,
    output logic [3:0]            o_sel_idx
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_ERR} state_t;

    state_t           state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    data_q, data_d;
    logic [DW/8-1:0]  sel_q, sel_d;
    logic             we_q, we_d;

    logic             hit_s;
    logic [3:0]       hit_idx_s;
    logic             g_stall_s, g_ack_s, ack_ok_s, busy_s, timeout_s;
    logic [DW-1:0]    g_data_s;

    // Address decode; scanning downwards lets the lowest matching slot win.
    always_comb begin
        hit_s     = 1'b0;
        hit_idx_s = 4'd0;
        for (int i = NSLAVES - 1; i >= 0; i--) begin
            hit_idx_s = ((i_wb_addr & SLAVE_MASK[i*AW +: AW]) == SLAVE_BASE[i*AW +: AW]) ? 4'(i) : hit_idx_s;
            hit_s     = hit_s | ((i_wb_addr & SLAVE_MASK[i*AW +: AW]) == SLAVE_BASE[i*AW +: AW]);
        end
    end

    // Mux the granted slave's stall/ack/data; other slaves are invisible to the master.
    always_comb begin
        g_stall_s = 1'b0;
        g_ack_s   = 1'b0;
        g_data_s  = '0;
        for (int i = 0; i < NSLAVES; i++) begin
            g_stall_s = g_stall_s | (i_s_stall[i] & (idx_q == 4'(i)));
            g_ack_s   = g_ack_s   | (i_s_ack[i]   & (idx_q == 4'(i)));
            g_data_s  = g_data_s  | (i_s_data[i*DW +: DW] & {DW{idx_q == 4'(i)}});
        end
    end

    assign busy_s   = (state_q == ST_REQ) || (state_q == ST_WAIT);
    // A master abort (cyc low) suppresses any ack arriving in the same cycle.
    assign ack_ok_s = i_wb_cyc && g_ack_s &&
                      ((state_q == ST_WAIT) || ((state_q == ST_REQ) && !g_stall_s));

`ifdef WB_DECODER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    // Counter is zero in IDLE, so it starts from zero on every REQ entry.
    always_comb begin
        cnt_d = busy_s ? cnt_q + CW'(1) : '0;
    end
    assign timeout_s = (cnt_q == CW'(TIMEOUT - 1));
`else
    logic unused_timeout_s;
    assign unused_timeout_s = (TIMEOUT > 1);
    assign timeout_s        = 1'b0;
`endif

    // Next-state and request latch logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        data_d  = data_q;
        sel_d   = sel_q;
        we_d    = we_q;
        case (state_q)
            ST_IDLE: begin
                if (i_wb_cyc && i_wb_stb) begin
                    addr_d  = i_wb_addr;
                    data_d  = i_wb_data;
                    sel_d   = i_wb_sel;
                    we_d    = i_wb_we;
                    idx_d   = hit_s ? hit_idx_s : 4'd0;
                    state_d = hit_s ? ST_REQ : ST_ERR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (!i_wb_cyc || ack_ok_s) begin
                    state_d = ST_IDLE;
                end else if (timeout_s) begin
                    state_d = ST_ERR;
                end else if (!g_stall_s) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (!i_wb_cyc || ack_ok_s) begin
                    state_d = ST_IDLE;
                end else if (timeout_s) begin
                    state_d = ST_ERR;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and latched-request registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 4'd0;
            addr_q  <= '0;
            data_q  <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
`ifdef WB_DECODER_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
`ifdef WB_DECODER_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Slave-side strobes decoded purely from registered state.
    always_comb begin
        o_s_cyc = '0;
        o_s_stb = '0;
        for (int i = 0; i < NSLAVES; i++) begin
            o_s_cyc[i] = busy_s && (idx_q == 4'(i));
            o_s_stb[i] = (state_q == ST_REQ) && (idx_q == 4'(i));
        end
    end

    assign o_wb_ack   = ack_ok_s;
    assign o_wb_data  = ack_ok_s ? g_data_s : '0;
    assign o_wb_err   = (state_q == ST_ERR);
    assign o_wb_stall = (state_q != ST_IDLE);
    assign o_busy     = (state_q != ST_IDLE);
    assign o_sel_idx  = idx_q;
    assign o_s_we     = we_q;
    assign o_s_addr   = addr_q;
    assign o_s_data   = data_q;
    assign o_s_sel    = sel_q;

endmodule

// File: tb/tb_wb_decoder_n.sv
// Scoreboard bench for wb_decoder_n: directed transactions push expected master responses,
// a negedge monitor pops and compares whenever ack or err is presented.
module tb_wb_decoder_n;
    localparam int NS = 4;
    localparam int TO = 8;

    logic          clk, rst;
    logic          wb_cyc, wb_stb, wb_we;
    logic [31:0]   wb_addr, wb_data;
    logic [3:0]    wb_sel;
    logic          o_wb_stall, o_wb_ack, o_wb_err;
    logic [31:0]   o_wb_data;
    logic [NS-1:0] o_s_cyc, o_s_stb;
    logic          o_s_we;
    logic [31:0]   o_s_addr, o_s_data;
    logic [3:0]    o_s_sel;
    logic [NS-1:0] s_stall, s_ack;
    logic [127:0]  s_data;
    logic          o_busy;
    logic [3:0]    o_sel_idx;

    typedef struct {
        logic        err;
        logic [31:0] data;
    } exp_t;
    exp_t sb_q[$];

    int checks = 0;
    int errors = 0;

    wb_decoder_n #(.NSLAVES(NS), .AW(32), .DW(32), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb), .i_wb_we(wb_we),
        .i_wb_addr(wb_addr), .i_wb_data(wb_data), .i_wb_sel(wb_sel),
        .o_wb_stall(o_wb_stall), .o_wb_ack(o_wb_ack), .o_wb_err(o_wb_err), .o_wb_data(o_wb_data),
        .o_s_cyc(o_s_cyc), .o_s_stb(o_s_stb), .o_s_we(o_s_we),
        .o_s_addr(o_s_addr), .o_s_data(o_s_data), .o_s_sel(o_s_sel),
        .i_s_stall(s_stall), .i_s_ack(s_ack), .i_s_data(s_data),
        .o_busy(o_busy), .o_sel_idx(o_sel_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every master response must match the oldest queued expectation.
    always @(negedge clk) begin
        if (o_wb_ack || o_wb_err) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp ack=%0b err=%0b data=%0h (no response required)",
                         o_wb_ack, o_wb_err, o_wb_data);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("resp_err",  {127'd0, o_wb_err}, {127'd0, e.err});
                chk("resp_ack",  {127'd0, o_wb_ack}, {127'd0, !e.err});
                chk("resp_data", {96'd0, o_wb_data}, {96'd0, e.data});
            end
        end
    end

    // One master transaction; slave 'slv' stalls for stall_n cycles and acks at cycle ack_at (0 = never).
    // Every other slave acks continuously so a stray grant would be noticed. exp_done 0 = no completion.
    task automatic run_txn(input string tag, input logic [31:0] addr, input logic we,
                           input logic [31:0] wdata, input logic [3:0] sel, input int slv,
                           input int stall_n, input int ack_at, input logic [31:0] rdata,
                           input logic exp_err, input int exp_done, input int exp_stb, input int limit);
        int k, done, stb_n, cyc_n;
        logic [3:0] oh;
        exp_t e;
        oh     = 4'b0001 << slv;
        s_data = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0BAD_0000};
        s_data[slv*32 +: 32] = rdata;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_addr = addr; wb_data = wdata; wb_sel = sel;
        if (exp_done != 0) begin
            e.err  = exp_err;
            e.data = exp_err ? 32'h0 : rdata;
            sb_q.push_back(e);
        end
        tick();
        wb_stb = 1'b0;
        k = 1; done = 0; stb_n = 0; cyc_n = 0;
        while (done == 0 && k <= limit) begin
            s_stall = (k <= stall_n) ? oh : 4'b0000;
            s_ack   = (ack_at != 0 && k == ack_at) ? oh : ~oh;
            @(negedge clk);
            if (o_s_stb != 4'b0000) begin
                stb_n++;
                if (stb_n == 1) begin
                    chk({tag, "_stb"},  {124'd0, o_s_stb},   {124'd0, oh});
                    chk({tag, "_idx"},  {124'd0, o_sel_idx}, 128'(slv));
                    chk({tag, "_addr"}, {96'd0, o_s_addr},   {96'd0, addr});
                    chk({tag, "_wdat"}, {96'd0, o_s_data},   {96'd0, wdata});
                    chk({tag, "_sel"},  {124'd0, o_s_sel},   {124'd0, sel});
                    chk({tag, "_we"},   {127'd0, o_s_we},    {127'd0, we});
                end
            end
            if (o_s_cyc != 4'b0000) cyc_n++;
            if (o_wb_ack || o_wb_err) done = k;
            tick();
            k++;
        end
        wb_cyc = 1'b0; s_ack = 4'b0000; s_stall = 4'b0000;
        chk({tag, "_done_cycle"}, 128'(done), 128'(exp_done));
        chk({tag, "_stb_cycles"}, 128'(stb_n), 128'(exp_stb));
        if (exp_stb == 0) chk({tag, "_cyc_cycles"}, 128'(cyc_n), 128'd0);
        tick();
        @(negedge clk);
        chk({tag, "_idle_after"}, {123'd0, o_busy, o_s_cyc}, 128'd0);
        tick();
    endtask

    initial begin
        rst = 1'b1; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        wb_addr = 32'h0; wb_data = 32'h0; wb_sel = 4'h0;
        s_stall = 4'b0000; s_ack = 4'b0000; s_data = '0;
        tick(); tick();
        @(negedge clk);
        chk("reset_outputs", {11'd0, o_wb_stall, o_wb_ack, o_wb_err, o_wb_data, o_s_cyc, o_s_stb, o_s_we,
                              o_s_addr, o_s_data, o_s_sel, o_busy, o_sel_idx}, 128'd0);
        tick();
        rst = 1'b0;
        tick();

        // Read hit on slave 1, slave acks two cycles after the strobe.
        run_txn("rd_s1", 32'h0001_0040, 1'b0, 32'h0, 4'hF, 1, 0, 3, 32'hDEAD_BEEF, 1'b0, 3, 1, 50);
        // Write to slave 3 with three stall cycles: strobe held four cycles.
        run_txn("wr_s3", 32'h8000_0010, 1'b1, 32'h0000_00A5, 4'b0001, 3, 3, 5, 32'h0, 1'b0, 5, 4, 50);
        // Unmapped address: error one cycle after acceptance, no slave touched.
        run_txn("miss", 32'h2000_0000, 1'b0, 32'h0, 4'hF, 0, 0, 0, 32'h0, 1'b1, 1, 0, 50);
        // Slave 0 never acks.
`ifdef WB_DECODER_TIMEOUT_EN
        run_txn("tmo", 32'h0000_0100, 1'b0, 32'h0, 4'hF, 0, 0, 0, 32'h0, 1'b1, TO + 1, 1, 50);
`else
        run_txn("tmo", 32'h0000_0100, 1'b0, 32'h0, 4'hF, 0, 0, 0, 32'h0, 1'b0, 0, 1, 1000);
`endif
        // Combinational-ack slave 2 answers in the strobe cycle.
        run_txn("rd_s2", 32'h4000_2000, 1'b0, 32'h0, 4'hF, 2, 0, 1, 32'h1234_5678, 1'b0, 1, 1, 50);

        // Master abort in WAIT with a same-cycle ack: nothing reaches the master.
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_addr = 32'h4000_1000;
        tick();
        wb_stb = 1'b0;
        tick();
        wb_cyc = 1'b0; s_ack = 4'b0100;
        @(negedge clk);
        chk("abort_no_ack", {127'd0, o_wb_ack}, 128'd0);
        tick();
        @(negedge clk);
        chk("abort_idle", {122'd0, o_busy, o_wb_ack, o_s_cyc}, 128'd0);
        tick();
        s_ack = 4'b0000;
        run_txn("post_abort", 32'h4000_3000, 1'b1, 32'h0000_5A5A, 4'b0011, 2, 1, 3, 32'hCAFE_0001, 1'b0, 3, 2, 50);

        // Reset asserted in WAIT: everything clears and a late ack is ignored.
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_addr = 32'h0001_0080; wb_data = 32'h7777_0000;
        tick();
        wb_stb = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; s_ack = 4'b0010;
        @(negedge clk);
        chk("rst_mid_outputs", {11'd0, o_wb_stall, o_wb_ack, o_wb_err, o_wb_data, o_s_cyc, o_s_stb, o_s_we,
                                o_s_addr, o_s_data, o_s_sel, o_busy, o_sel_idx}, 128'd0);
        tick();
        @(negedge clk);
        chk("rst_late_ack", {126'd0, o_wb_ack, o_wb_err}, 128'd0);
        tick();
        wb_cyc = 1'b0; s_ack = 4'b0000;
        tick();
        run_txn("post_rst", 32'h0000_0004, 1'b0, 32'h0, 4'hF, 0, 0, 2, 32'h0F0F_F0F0, 1'b0, 2, 1, 50);

        chk("scoreboard_empty", 128'(sb_q.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
